dmem_unit: RTL and testbench

Parametrised data-memory unit for the MIPS core's memory stage. It is the successor to the fixed 4 KiB byte-enable data RAM. It accepts load/store requests over a valid/ready handshake and decodes byte, halfword and word sizes into lane enables internally. Loads are zero- or sign-extended, misaligned accesses are flagged, and an optional output register is available. After reset the RAM is zeroed by a hardware clear sequence, replacing simulation-only initialisation.

---
 rtl/dmem_unit.sv | 179 +++++++++++++++++
 tb/tb_dmem_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_unit.sv
// Data-memory unit for the MIPS memory stage: sized loads/stores over valid/ready,
// little-endian lane mapping, load extension, misalignment flagging and a hardware clear after reset.
module dmem_unit #(
  parameter int ADDR_BITS = 12,
  parameter int OUT_REG   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        busy
);

  localparam int IDX_W = ADDR_BITS - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   clr_cnt_q;
  logic               req_ready_q;
  logic               busy_q;

  logic [31:0]        mem_q [DEPTH];
  logic [31:0]        rd_word_q;

  logic               accept;
  logic               clearing;
  logic               store_en;
  logic               req_mis;
  logic [3:0]         st_be;
  logic [31:0]        st_data;
  logic [IDX_W-1:0]   req_idx;

  logic               p1_valid_q;
  logic               p1_mis_q;
  logic               p1_we_q;
  logic [1:0]         p1_size_q;
  logic               p1_signed_q;
  logic [1:0]         p1_off_q;
  logic [7:0]         lane_byte;
  logic [15:0]        lane_half;
  logic [31:0]        p1_rdata;

  // Upper address bits are deliberately ignored so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_BITS];

  // A request arriving on a reset edge is dropped together with everything in flight.
  assign accept    = req_valid & req_ready_q & ~rst;
  assign clearing  = (state_q == S_CLEAR);
  assign req_idx   = addr[ADDR_BITS-1:2];
  assign store_en  = accept & req_we & ~req_mis;
  assign req_ready = req_ready_q;
  assign busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      clr_cnt_q   <= '0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + IDX_W'(1);
          if (&clr_cnt_q) begin
            state_q     <= S_RUN;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    req_mis = 1'b0;
    st_be   = 4'b1111;
    st_data = wdata;
    case (req_size)
      2'b00: begin
        st_be   = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        req_mis = addr[0];
        st_be   = addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata[15:0]}};
      end
      2'b10:   req_mis = |addr[1:0];
      default: req_mis = 1'b1;
    endcase
  end

  // NOTE: the RAM array has no reset branch; the clear sequence zeroes it instead,
  // which keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (store_en) begin
      for (int k = 0; k < 4; k++) begin
        if (st_be[k]) mem_q[req_idx][8*k +: 8] <= st_data[8*k +: 8];
      end
    end
    if (accept) rd_word_q <= mem_q[req_idx];
  end

  // Request attributes travel alongside the RAM read for extraction.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid_q  <= 1'b0;
      p1_mis_q    <= 1'b0;
      p1_we_q     <= 1'b0;
      p1_size_q   <= '0;
      p1_signed_q <= 1'b0;
      p1_off_q    <= '0;
    end else begin
      p1_valid_q <= accept;
      if (accept) begin
        p1_mis_q    <= req_mis;
        p1_we_q     <= req_we;
        p1_size_q   <= req_size;
        p1_signed_q <= req_signed;
        p1_off_q    <= addr[1:0];
      end
    end
  end

  always_comb begin
    lane_byte = rd_word_q[{p1_off_q, 3'b000} +: 8];
    lane_half = p1_off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    p1_rdata  = '0;
    if (p1_valid_q && !p1_mis_q && !p1_we_q) begin
      case (p1_size_q)
        2'b00:   p1_rdata = {{24{p1_signed_q & lane_byte[7]}}, lane_byte};
        2'b01:   p1_rdata = {{16{p1_signed_q & lane_half[15]}}, lane_half};
        default: p1_rdata = rd_word_q;
      endcase
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic        rsp_valid_q;
    logic        mis_q;
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rsp_valid_q <= 1'b0;
        mis_q       <= 1'b0;
        rdata_q     <= '0;
      end else begin
        rsp_valid_q <= p1_valid_q;
        mis_q       <= p1_valid_q & p1_mis_q;
        rdata_q     <= p1_rdata;
      end
    end

    assign rsp_valid  = rsp_valid_q;
    assign misaligned = mis_q;
    assign rdata      = rdata_q;
  end else begin : g_no_out_reg
    assign rsp_valid  = p1_valid_q;
    assign misaligned = p1_valid_q & p1_mis_q;
    assign rdata      = p1_rdata;
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: one stimulus stream drives an OUT_REG=0 and an OUT_REG=1 instance,
// each with its own expected-response queue drained by a monitor against a byte-level memory model.
module tb_dmem_unit;

  localparam int AB    = 6;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic        req_ready0, rsp_valid0, mis0, busy0;
  logic        req_ready1, rsp_valid1, mis1, busy1;
  logic [31:0] rdata0, rdata1;

  dmem_unit #(.ADDR_BITS(AB), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid0), .rdata(rdata0),
    .misaligned(mis0), .busy(busy0)
  );

  dmem_unit #(.ADDR_BITS(AB), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid1), .rdata(rdata1),
    .misaligned(mis1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt++;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          edge_n;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] mem_m [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid0) begin
      if (q0.size() == 0) check("rsp0_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q0.pop_front();
        check("rdata0", rdata0, e.rdata);
        check("mis0", 32'(mis0), 32'(e.mis));
        check("lat0", 32'(edge_cnt), 32'(e.edge_n));
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_valid1) begin
      if (q1.size() == 0) check("rsp1_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q1.pop_front();
        check("rdata1", rdata1, e.rdata);
        check("mis1", 32'(mis1), 32'(e.mis));
        check("lat1", 32'(edge_cnt), 32'(e.edge_n));
      end
    end
  end

  function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return a[1:0] != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sgn,
                                             input logic [31:0] a);
    int hb = int'(a[5:1]) * 2;
    int wb = int'(a[5:2]) * 4;
    logic [7:0]  b = mem_m[int'(a[5:0])];
    logic [15:0] h = {mem_m[hb+1], mem_m[hb]};
    case (sz)
      2'd0:    return (sgn && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
      2'd1:    return (sgn && h[15]) ? {16'hFFFF, h} : {16'h0, h};
      default: return {mem_m[wb+3], mem_m[wb+2], mem_m[wb+1], mem_m[wb]};
    endcase
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int hb = int'(a[5:1]) * 2;
    int wb = int'(a[5:2]) * 4;
    case (sz)
      2'd0: mem_m[int'(a[5:0])] = d[7:0];
      2'd1: begin
        mem_m[hb]   = d[7:0];
        mem_m[hb+1] = d[15:8];
      end
      default: for (int i = 0; i < 4; i++) mem_m[wb+i] = d[8*i +: 8];
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Holds the request until accepted, then pushes the expected response(s).
  task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit use_model, input logic [31:0] exp_rd,
                       input logic exp_mis, input bit drop1);
    int   waited = 0;
    exp_t e;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sgn;
    addr       = a;
    wdata      = d;
    while (!req_ready0 && waited < 100) begin
      tick();
      waited++;
    end
    if (!req_ready0) begin
      check("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    tick();
    e.edge_n = edge_cnt;
    e.mis    = model_mis(sz, a);
    if (we) begin
      e.rdata = '0;
      if (!e.mis) model_store(sz, a, d);
    end else begin
      e.rdata = e.mis ? 32'd0 : model_load(sz, sgn, a);
    end
    if (!use_model) begin
      e.rdata = exp_rd;
      e.mis   = exp_mis;
    end
    q0.push_back(e);
    if (!drop1) begin
      e.edge_n = edge_cnt + 1;
      q1.push_back(e);
    end
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    issue(1'b1, sz, 1'b0, a, d, 1'b1, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic ld_exp(input logic [1:0] sz, input logic sgn, input logic [31:0] a,
                        input logic [31:0] exp, input logic exp_mis);
    issue(1'b0, sz, sgn, a, 32'd0, 1'b0, exp, exp_mis, 1'b0);
  endtask

  // Pulses reset (optionally again partway through the clear) and times the clear.
  task automatic do_reset(input int mid_clear);
    int cnt = 0;
    req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    check("rst_busy0", 32'(busy0), 32'd1);
    check("rst_busy1", 32'(busy1), 32'd1);
    check("rst_ready0", 32'(req_ready0), 32'd0);
    check("rst_ready1", 32'(req_ready1), 32'd0);
    check("rst_rsp0", {rdata0[30:0], rsp_valid0}, 32'd0);
    check("rst_rsp1", {rdata1[30:0], rsp_valid1}, 32'd0);
    check("rst_mis", 32'(mis0 | mis1), 32'd0);
    rst = 1'b0;
    if (mid_clear > 0) begin
      repeat (mid_clear) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    do begin
      tick();
      cnt++;
    end while (busy0 && cnt < 100);
    check("clear_len", 32'(cnt), 32'(DEPTH));
    check("ready_after_clear0", 32'(req_ready0), 32'd1);
    check("ready_after_clear1", 32'(req_ready1), 32'd1);
    check("busy1_after_clear", 32'(busy1), 32'd0);
    check("q_empty_after_reset", 32'(q0.size() + q1.size()), 32'd0);
    for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset(0);

    ld_exp(2'd2, 1'b0, 32'h3C, 32'h00000000, 1'b0);

    st(2'd2, 32'h10, 32'h11223344);
    st(2'd0, 32'h12, 32'h000000AA);
    st(2'd1, 32'h10, 32'h0000BEEF);
    ld_exp(2'd2, 1'b0, 32'h10, 32'h11AABEEF, 1'b0);

    st(2'd2, 32'h20, 32'h80FF7F01);
    ld_exp(2'd0, 1'b1, 32'h22, 32'hFFFFFFFF, 1'b0);
    ld_exp(2'd0, 1'b0, 32'h23, 32'h00000080, 1'b0);
    ld_exp(2'd1, 1'b1, 32'h20, 32'h00007F01, 1'b0);
    ld_exp(2'd1, 1'b1, 32'h22, 32'hFFFF80FF, 1'b0);

    issue(1'b1, 2'd1, 1'b0, 32'h21, 32'h00001234, 1'b0, 32'd0, 1'b1, 1'b0);
    ld_exp(2'd2, 1'b0, 32'h20, 32'h80FF7F01, 1'b0);
    ld_exp(2'd2, 1'b0, 32'h22, 32'h00000000, 1'b1);
    ld_exp(2'd3, 1'b0, 32'h00, 32'h00000000, 1'b1);

    st(2'd2, 32'h08, 32'hCAFEBABE);
    ld_exp(2'd2, 1'b0, 32'h08, 32'hCAFEBABE, 1'b0);

    st(2'd2, 32'h40, 32'h5A5A5A5A);
    ld_exp(2'd2, 1'b0, 32'h00, 32'h5A5A5A5A, 1'b0);
    idle(3);

    for (int i = 0; i < 300; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0) idle(1);
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'd0;
      end
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
            1'b1, 32'd0, 1'b0, 1'b0);
    end
    idle(3);

    do_reset(5);
    ld_exp(2'd2, 1'b0, 32'h10, 32'h00000000, 1'b0);

    st(2'd2, 32'h10, 32'h13572468);
    idle(1);
    // The OUT_REG=1 response to this load is still in flight when reset lands.
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0, 32'h13572468, 1'b0, 1'b1);
    do_reset(0);
    ld_exp(2'd2, 1'b0, 32'h10, 32'h00000000, 1'b0);
    idle(4);

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
